// File: rtl/note_highway.sv
// Note highway: up to NROWS lane-mask rows scroll down the screen and are drawn per scan position.
// Optional pad-hit judging is compiled in with `define HIT_WINDOW_EN.
module note_highway #(
    parameter int              LANES  = 5,
    parameter int              NROWS  = 4,
    parameter int              X0     = 80,
    parameter int              PITCH  = 96,
    parameter int              SIZE   = 64,
    parameter int              END_Y  = 480,
    parameter logic [LANES*8-1:0] COLORS = {8'hF8, 8'h03, 8'hFC, 8'h1C, 8'hE0},
    parameter logic [7:0]      BG     = 8'hFF,
    parameter int              HIT_Y0 = 384,
    parameter int              HIT_Y1 = 448
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             video_on,
    input  logic [9:0]       presentX,
    input  logic [9:0]       presentY,
    input  logic             frame_tick,
    input  logic [2:0]       speed,
    input  logic             spawn_valid,
    input  logic [LANES-1:0] spawn_mask,
    output logic             spawn_ready,
    input  logic [LANES-1:0] pad,
    output logic [7:0]       pixel,
    output logic             pintar,
    output logic             hit_valid,
    output logic [LANES-1:0] hit_mask,
    output logic             retire_valid,
    output logic [LANES-1:0] miss_mask
);

    logic [NROWS-1:0] active_q, active_d;
    logic [10:0]      pos_q  [NROWS];
    logic [10:0]      pos_d  [NROWS];
    logic [LANES-1:0] mask_q [NROWS];
    logic [LANES-1:0] mask_d [NROWS];

    logic             retire_valid_q, retire_valid_d;
    logic [LANES-1:0] miss_mask_q, miss_mask_d;
    logic [7:0]       pixel_q, pixel_d;
    logic             pintar_q, pintar_d;

    logic             spawn_found;
    logic [10:0]      step_pos;

`ifdef HIT_WINDOW_EN
    logic [LANES-1:0] hit_mask_q, hit_mask_d;
    logic             best_found;
    int               best_r;
    logic [10:0]      best_pos;
`else
    logic             unused_hit_cfg;
    assign unused_hit_cfg = ^{pad, HIT_Y0[0], HIT_Y1[0]};
`endif

    assign spawn_ready = |(~active_q);

    // NOTE: combinational blocks use blocking assignments and give every target a default first, so no latches appear.
    always_comb begin
        active_d       = active_q;
        pos_d          = pos_q;
        mask_d         = mask_q;
        retire_valid_d = 1'b0;
        miss_mask_d    = '0;
        spawn_found    = 1'b0;
        step_pos       = '0;
`ifdef HIT_WINDOW_EN
        hit_mask_d = '0;
        best_found = 1'b0;
        best_r     = 0;
        best_pos   = '0;
        // Hits land before retirement so a hit lane never shows up as a miss.
        for (int k = 0; k < LANES; k++) begin
            best_found = 1'b0;
            best_r     = 0;
            best_pos   = '0;
            if (pad[k]) begin
                for (int r = 0; r < NROWS; r++) begin
                    if (active_q[r] && mask_q[r][k] &&
                        pos_q[r] >= 11'(HIT_Y0) && pos_q[r] <= 11'(HIT_Y1) &&
                        (!best_found || pos_q[r] > best_pos)) begin
                        best_found = 1'b1;
                        best_r     = r;
                        best_pos   = pos_q[r];
                    end
                end
                if (best_found) begin
                    hit_mask_d[k] = 1'b1;
                    for (int r = 0; r < NROWS; r++) begin
                        if (r == best_r) mask_d[r][k] = 1'b0;
                    end
                end
            end
        end
`endif
        if (frame_tick) begin
            for (int r = 0; r < NROWS; r++) begin
                if (active_q[r]) begin
                    step_pos = pos_q[r] + 11'(speed);
                    if (step_pos >= 11'(END_Y)) begin
                        active_d[r]    = 1'b0;
                        retire_valid_d = 1'b1;
                        miss_mask_d    = miss_mask_d | mask_d[r];
                    end else begin
                        pos_d[r] = step_pos;
                    end
                end
            end
        end
        // Only slots free before this edge are eligible, so a slot retiring now is not reused until the next edge.
        if (spawn_valid && spawn_ready) begin
            for (int r = 0; r < NROWS; r++) begin
                if (!spawn_found && !active_q[r]) begin
                    spawn_found = 1'b1;
                    active_d[r] = 1'b1;
                    pos_d[r]    = '0;
                    mask_d[r]   = spawn_mask;
                end
            end
        end
        if (clear) begin
            active_d       = '0;
            retire_valid_d = 1'b0;
            miss_mask_d    = '0;
            for (int r = 0; r < NROWS; r++) begin
                pos_d[r]  = '0;
                mask_d[r] = '0;
            end
`ifdef HIT_WINDOW_EN
            hit_mask_d = '0;
`endif
        end
    end

    always_comb begin
        pintar_d = 1'b0;
        pixel_d  = BG;
        // Descending scan lets the lowest-index slot overwrite the colour last.
        for (int r = NROWS - 1; r >= 0; r--) begin
            for (int k = 0; k < LANES; k++) begin
                if (active_q[r] && mask_q[r][k] &&
                    {1'b0, presentX} >= 11'(X0 + k * PITCH) &&
                    {1'b0, presentX} <  11'(X0 + k * PITCH + SIZE) &&
                    {1'b0, presentY} >= pos_q[r] &&
                    {1'b0, presentY} <  pos_q[r] + 11'(SIZE)) begin
                    pintar_d = 1'b1;
                    if (video_on) pixel_d = COLORS[8*k +: 8];
                end
            end
        end
    end

    // NOTE: the slot arrays are a handful of flops, not a RAM, so they are reset along with everything else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q       <= '0;
            retire_valid_q <= 1'b0;
            miss_mask_q    <= '0;
            pixel_q        <= BG;
            pintar_q       <= 1'b0;
            for (int r = 0; r < NROWS; r++) begin
                pos_q[r]  <= '0;
                mask_q[r] <= '0;
            end
        end else begin
            active_q       <= active_d;
            retire_valid_q <= retire_valid_d;
            miss_mask_q    <= miss_mask_d;
            pixel_q        <= pixel_d;
            pintar_q       <= pintar_d;
            for (int r = 0; r < NROWS; r++) begin
                pos_q[r]  <= pos_d[r];
                mask_q[r] <= mask_d[r];
            end
        end
    end

`ifdef HIT_WINDOW_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) hit_mask_q <= '0;
        else       hit_mask_q <= hit_mask_d;
    end
    assign hit_mask  = hit_mask_q;
    assign hit_valid = |hit_mask_q;
`else
    assign hit_mask  = '0;
    assign hit_valid = 1'b0;
`endif

    assign pixel        = pixel_q;
    assign pintar       = pintar_q;
    assign retire_valid = retire_valid_q;
    assign miss_mask    = miss_mask_q;

endmodule
